// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, a small prefetch FIFO
// toward decode, and redirect handling that flushes the FIFO and discards in-flight data.
module instruction_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dec_valid,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_instr_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem    [DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W-1:0]  w_count_after_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    endfunction

    assign w_valid           = (r_count != '0);
    assign w_pop             = w_valid && dec_ready && !redirect;
    assign w_push            = (r_state == S_WAIT) && mem_ack && !redirect;
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    // Issue only if the word can land even when no pop happens before its ack.
    assign w_issue           = (r_state == S_IDLE) && !redirect && (w_count_after_pop < FULL_CNT);

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign dec_valid = w_valid;
    assign dec_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign dec_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;

    // NOTE: the FIFO storage has no reset; its contents are never observed while count is 0.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= mem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state    <= S_WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        if (!redirect) r_fetch_pc <= r_fetch_pc + 1'b1;
                    end else if (redirect) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
            if (redirect) r_fetch_pc <= redirect_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirects, reset and PC wrap.
module tb_instruction_fetch;

    logic        Clock;
    logic        Reset;
    logic        mem_req, mem_ack, dec_valid, dec_ready, redirect;
    logic [15:0] mem_addr, mem_rdata, dec_instr, dec_pc, redirect_pc;

    logic        mem_req2, mem_ack2, dec_valid2;
    logic [15:0] mem_addr2, mem_rdata2, dec_instr2, dec_pc2;
    logic        dec_ready2, redirect2;
    logic [15:0] redirect_pc2;

    int          n_tests, n_fail;
    bit          resp_en;
    int          ack_lat, slow_lat, wait_cnt;
    logic [15:0] slow_addr;
    logic [15:0] q_acked[$];
    logic [15:0] q_pop_pc[$];
    logic [15:0] q_pop_instr[$];
    logic [15:0] q2[$];

    instruction_fetch dut (
        .Clock(Clock), .Reset(Reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
        .Clock(Clock), .Reset(Reset),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .dec_valid(dec_valid2), .dec_instr(dec_instr2), .dec_pc(dec_pc2), .dec_ready(dec_ready2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    function automatic logic [15:0] mdl(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Memory responder and event logger, both acting on the falling edge.
    always @(negedge Clock) begin
        if (resp_en) begin
            if (mem_req) begin
                if (wait_cnt >= ((mem_addr == slow_addr) ? slow_lat : ack_lat)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mdl(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
        if (mem_req && mem_ack) q_acked.push_back(mem_addr);
        if (dec_valid && dec_ready && !redirect) begin
            q_pop_pc.push_back(dec_pc);
            q_pop_instr.push_back(dec_instr);
        end
        mem_ack2   = mem_req2;
        mem_rdata2 = mdl(mem_addr2);
        if (mem_req2 && mem_ack2) q2.push_back(mem_addr2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input bit en);
        Reset   = 1'b1;
        resp_en = en;
        mem_ack = 1'b0;
        redirect = 1'b0;
        dec_ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        q_acked.delete();
        q_pop_pc.delete();
        q_pop_instr.delete();
        q2.delete();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clock);
        #1;
        n_tests++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (mem_addr !== 16'h0)  begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_tests++; if (dec_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        n_tests++; if (dec_instr !== 16'h0) begin n_fail++; $display("FAIL reset_dec_instr: got %h want 0000", dec_instr); end
        n_tests++; if (dec_pc !== 16'h0)    begin n_fail++; $display("FAIL reset_dec_pc: got %h want 0000", dec_pc); end
        Reset = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL release_no_req: got %b want 0", mem_req); end
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_stream();
        int k;
        do_reset(1'b1);
        dec_ready = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0 || dec_instr !== mdl(16'h0)) begin
            n_fail++; $display("FAIL push_latency: got v=%b pc=%h i=%h want v=1 pc=0000 i=%h", dec_valid, dec_pc, dec_instr, mdl(16'h0));
        end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL no_back_to_back: got req=%b want 0", mem_req); end
        @(negedge Clock);
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h1) begin
            n_fail++; $display("FAIL second_issue: got req=%b addr=%h want req=1 addr=0001", mem_req, mem_addr);
        end
        k = 0;
        while (q_pop_pc.size() < 4 && k < 40) begin @(negedge Clock); k++; end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (q_acked.size() <= i || q_acked[i] !== 16'(i)) begin
                n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, (q_acked.size() > i) ? q_acked[i] : 16'hxxxx, 16'(i));
            end
            n_tests++; if (q_pop_pc.size() <= i || q_pop_pc[i] !== 16'(i) || q_pop_instr[i] !== mdl(16'(i))) begin
                n_fail++; $display("FAIL stream_pop[%0d]: got pc=%h i=%h want pc=%h i=%h", i,
                    (q_pop_pc.size() > i) ? q_pop_pc[i] : 16'hxxxx, (q_pop_instr.size() > i) ? q_pop_instr[i] : 16'hxxxx, 16'(i), mdl(16'(i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset(1'b1);
        repeat (12) @(negedge Clock);
        n_tests++; if (q_acked.size() != 2) begin n_fail++; $display("FAIL bp_push_count: got %0d want 2", q_acked.size()); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_held: got %b want 0", mem_req); end
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0) begin
            n_fail++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0000", dec_valid, dec_pc);
        end
        @(posedge Clock); #1;
        dec_ready = 1'b1;
        k = 0;
        while (q_pop_pc.size() < 3 && k < 40) begin @(negedge Clock); k++; end
        n_tests++; if (q_acked.size() < 3 || q_acked[2] !== 16'h2) begin
            n_fail++; $display("FAIL bp_resume_addr: got %h want 0002", (q_acked.size() > 2) ? q_acked[2] : 16'hxxxx);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (q_pop_pc.size() <= i || q_pop_pc[i] !== 16'(i) || q_pop_instr[i] !== mdl(16'(i))) begin
                n_fail++; $display("FAIL bp_order[%0d]: got pc=%h want %h", i, (q_pop_pc.size() > i) ? q_pop_pc[i] : 16'hxxxx, 16'(i));
            end
        end
    endtask

    task automatic test_redirect_wait();
        int          k;
        bit          seen_new, found5;
        logic [15:0] first_new;
        do_reset(1'b1);
        dec_ready = 1'b1;
        slow_addr = 16'h5;
        slow_lat  = 3;
        k = 0;
        while (!(mem_req && mem_addr == 16'h5) && k < 60) begin @(negedge Clock); k++; end
        n_tests++; if (!(mem_req === 1'b1 && mem_addr === 16'h5)) begin
            n_fail++; $display("FAIL rw_reach5: got req=%b addr=%h want req=1 addr=0005", mem_req, mem_addr);
        end
        @(posedge Clock); #1;
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(posedge Clock); #1;
        redirect = 1'b0;
        n_tests++; if (dec_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h5) begin
            n_fail++; $display("FAIL rw_discard: got v=%b req=%b addr=%h want v=0 req=1 addr=0005", dec_valid, mem_req, mem_addr);
        end
        seen_new = 1'b0; first_new = 16'h0;
        k = 0;
        while (dec_valid !== 1'b1 && k < 30) begin
            @(negedge Clock);
            if (mem_req && mem_addr != 16'h5 && !seen_new) begin seen_new = 1'b1; first_new = mem_addr; end
            k++;
        end
        n_tests++; if (first_new !== 16'h0040) begin n_fail++; $display("FAIL rw_next_addr: got %h want 0040", first_new); end
        n_tests++; if (dec_pc !== 16'h0040 || dec_instr !== mdl(16'h0040)) begin
            n_fail++; $display("FAIL rw_first_valid: got pc=%h i=%h want pc=0040 i=%h", dec_pc, dec_instr, mdl(16'h0040));
        end
        found5 = 1'b0;
        foreach (q_pop_pc[i]) if (q_pop_pc[i] == 16'h5) found5 = 1'b1;
        n_tests++; if (found5 !== 1'b0) begin n_fail++; $display("FAIL rw_word5_dropped: got popped=%b want 0", found5); end
        slow_addr = 16'hFFFF;
        slow_lat  = 0;
    endtask

    task automatic test_redirect_ack();
        do_reset(1'b0);
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL ra_issue: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = mdl(16'h0); redirect = 1'b1; redirect_pc = 16'h0080;
        @(posedge Clock); #1;
        mem_ack = 1'b0; redirect = 1'b0;
        n_tests++; if (dec_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL ra_dropped: got v=%b req=%b want v=0 req=0", dec_valid, mem_req);
        end
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0080) begin
            n_fail++; $display("FAIL ra_next: got req=%b addr=%h want req=1 addr=0080", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = mdl(16'h0080);
        @(posedge Clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0080 || dec_instr !== mdl(16'h0080)) begin
            n_fail++; $display("FAIL ra_arrive: got v=%b pc=%h want v=1 pc=0080", dec_valid, dec_pc);
        end
    endtask

    task automatic test_redirect_discard_idle();
        do_reset(1'b0);
        @(posedge Clock); #1;
        redirect = 1'b1; redirect_pc = 16'h0010;
        @(posedge Clock); #1;
        redirect_pc = 16'h0020;
        @(posedge Clock); #1;
        redirect = 1'b0;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL rd_hold: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge Clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (mem_req !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_drop: got req=%b v=%b want req=0 v=0", mem_req, dec_valid);
        end
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin
            n_fail++; $display("FAIL rd_reload: got req=%b addr=%h want req=1 addr=0020", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = mdl(16'h0020);
        @(posedge Clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0020) begin
            n_fail++; $display("FAIL rd_push: got v=%b pc=%h want v=1 pc=0020", dec_valid, dec_pc);
        end
        redirect = 1'b1; redirect_pc = 16'h0030;
        @(posedge Clock); #1;
        redirect = 1'b0;
        n_tests++; if (mem_req !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL ri_flush: got req=%b v=%b want req=0 v=0", mem_req, dec_valid);
        end
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0030) begin
            n_fail++; $display("FAIL ri_next: got req=%b addr=%h want req=1 addr=0030", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        @(posedge Clock); #1;
        mem_ack = 1'b1; mem_rdata = mdl(16'h0);
        @(posedge Clock); #1;
        mem_ack = 1'b0;
        @(posedge Clock); #1;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h1 || dec_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre: got req=%b addr=%h v=%b want req=1 addr=0001 v=1", mem_req, mem_addr, dec_valid);
        end
        #3;
        Reset = 1'b1;
        #1;
        n_tests++; if (mem_req !== 1'b0 || dec_valid !== 1'b0 || mem_addr !== 16'h0 || dec_pc !== 16'h0 || dec_instr !== 16'h0) begin
            n_fail++; $display("FAIL rm_async: got req=%b v=%b addr=%h pc=%h i=%h want all 0", mem_req, dec_valid, mem_addr, dec_pc, dec_instr);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(posedge Clock); #1;
        mem_ack = 1'b0;
        n_tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0 || dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_restart: got req=%b addr=%h v=%b want req=1 addr=0000 v=0", mem_req, mem_addr, dec_valid);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr[3];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000;
        do_reset(1'b1);
        repeat (10) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (q2.size() <= i || q2[i] !== exp_addr[i]) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, (q2.size() > i) ? q2[i] : 16'hxxxx, exp_addr[i]);
            end
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        Reset        = 1'b1;
        resp_en      = 1'b1;
        ack_lat      = 0;
        slow_lat     = 0;
        slow_addr    = 16'hFFFF;
        wait_cnt     = 0;
        mem_ack      = 1'b0;
        mem_rdata    = 16'h0;
        dec_ready    = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 16'h0;
        dec_ready2   = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = 16'h0;
        mem_ack2     = 1'b0;
        mem_rdata2   = 16'h0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_discard_idle();
        test_reset_mid();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the instruction address width in bits, word-addressed.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the instruction word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of entries in the prefetch buffer.
REQ-004 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-005 Port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port mem_req, output, 1 bit: instruction memory read request.
REQ-008 Port mem_addr, output, ADDR_W bits: read address, valid while mem_req=1.
REQ-009 Port mem_ack, input, 1 bit: read data valid this cycle; completes the outstanding request.
REQ-010 Port mem_rdata, input, DATA_W bits: instruction word, sampled when mem_ack=1.
REQ-011 Port dec_valid, output, 1 bit: an instruction is presented to the CPU decode stage.
REQ-012 Port dec_instr, output, DATA_W bits: instruction at the head of the buffer.
REQ-013 Port dec_pc, output, ADDR_W bits: address of dec_instr.
REQ-014 Port dec_ready, input, 1 bit: decode accepts dec_instr this cycle.
REQ-015 Port redirect, input, 1 bit: branch or jump taken; fetch restarts at redirect_pc.
REQ-016 Port redirect_pc, input, ADDR_W bits: target address, sampled when redirect=1.

Function
REQ-017 The FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding), and DISCARD (outstanding request whose data must be dropped).
REQ-018 The IDLE to WAIT transition SHALL occur, with mem_req=1 and mem_addr=fetch_pc registered, when count + 1 <= DEPTH after any pop in that cycle and redirect=0.
REQ-019 At most one request SHALL be outstanding; mem_req and mem_addr SHALL hold stable from assertion until the cycle in which mem_ack=1.
REQ-020 In WAIT with mem_ack=1 and redirect=0, the block SHALL push {fetch_pc, mem_rdata}, set fetch_pc to fetch_pc+1, and go to IDLE; mem_req SHALL drop on the following edge.
REQ-021 A back-to-back request SHALL NOT be issued in the ack cycle; the next request SHALL be issued in IDLE on the following cycle, giving a minimum 2-cycle issue interval.
REQ-022 fetch_pc increment SHALL wrap modulo 2^ADDR_W: 16'hFFFF followed by 16'h0000.
REQ-023 A pushed word SHALL appear on dec_valid/dec_instr/dec_pc in the cycle after its mem_ack.
REQ-024 dec_valid SHALL equal (count != 0); dec_instr and dec_pc SHALL reflect the oldest entry; a pop SHALL occur when dec_valid && dec_ready.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged with FIFO order preserved.
REQ-026 A push SHALL never occur when count = DEPTH (guaranteed by REQ-018); a pop when empty SHALL be ignored.
REQ-027 redirect=1 SHALL have priority over push, pop and issue: the buffer SHALL be flushed (count=0), fetch_pc SHALL be loaded with redirect_pc, and dec_valid SHALL be 0 the next cycle.
REQ-028 On redirect in WAIT with mem_ack=0, the state SHALL go to DISCARD; mem_req SHALL stay 1 with the old mem_addr until the ack.
REQ-029 On redirect in WAIT with mem_ack=1, the data SHALL be dropped and the state SHALL go to IDLE.
REQ-030 In DISCARD, mem_ack SHALL drop its data and go to IDLE; a further redirect in DISCARD SHALL only reload fetch_pc.
REQ-031 On redirect in IDLE, the state SHALL stay IDLE and the next request SHALL use redirect_pc.

Reset
REQ-032 While Reset=1, regardless of Clock: state=IDLE, mem_req=0, mem_addr=0, dec_valid=0, dec_instr=0, dec_pc=0, count=0, fetch_pc=RESET_PC.
REQ-033 Reset asserted mid-request SHALL abandon the request; any mem_ack after release with no request outstanding SHALL be ignored.
REQ-034 The first mem_req=1 with mem_addr=RESET_PC SHALL appear after the first rising Clock edge following Reset deassertion.

Verification
REQ-035 Scenario: reset, then ack every request 1 cycle after it is issued, dec_ready=1 -> mem_addr sequence 0,1,2,3; dec_pc follows the same sequence; dec_instr matches the memory model.
REQ-036 Scenario: dec_ready=0 with DEPTH=2 -> exactly 2 pushes, then mem_req stays 0 and dec_pc=0 is held; set dec_ready=1 -> fetch resumes at address 2.
REQ-037 Scenario: redirect to 16'h0040 while WAIT for address 5 with ack 3 cycles later -> word 5 discarded, next mem_addr=16'h0040, dec_valid=0 until the 16'h0040 word arrives.
REQ-038 Scenario: redirect in the same cycle as mem_ack -> acked word dropped, buffer empty, next request at redirect_pc.
REQ-039 Scenario: RESET_PC=16'hFFFE, free-running acks -> mem_addr sequence FFFE, FFFF, 0000.
REQ-040 Scenario: assert Reset between the clock edges of a WAIT cycle -> mem_req and dec_valid go 0 immediately; after release, fetch restarts at RESET_PC.
